// File: rtl/xor_stream_parity.sv
// xor_stream_parity
//   Accumulates per-lane and whole-frame XOR parity over a valid/ready word
//   stream framed by s_last, and emits one registered result record per frame.
//
// Parameters
//   WIDTH  data word width (multiple of LANES)
//   LANES  number of parity lanes; lane k covers bits [k*L +: L], L = WIDTH/LANES
//   CNT_W  beat counter width (saturating)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_odd    parity mode (0 even, 1 odd), captured on a frame's first beat
//   s_valid    input beat valid
//   s_ready    input beat accepted when s_valid && s_ready
//   s_data     input word
//   s_last     final beat of the frame
//   m_valid    result record valid
//   m_ready    result consumed when m_valid && m_ready
//   m_parity   per-lane frame parity, mode applied
//   m_total    whole-frame parity, mode applied
//   m_count    accepted beats in the frame, saturating
//   m_overflow beat count exceeded 2^CNT_W - 1
//
// State | meaning
// IDLE  | no frame open; next accepted beat starts a frame
// ACCUM | frame open; accepted beats fold into the accumulators

module xor_stream_parity #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_odd,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LANES-1:0] m_parity,
  output logic             m_total,
  output logic [CNT_W-1:0] m_count,
  output logic             m_overflow
);

  localparam int L = WIDTH / LANES;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] lane_acc_q, lane_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;

  logic             m_valid_q, m_valid_d;
  logic [LANES-1:0] m_parity_q, m_parity_d;
  logic             m_total_q, m_total_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;
  logic             m_overflow_q, m_overflow_d;

  logic [LANES-1:0] lp;
  logic             acc;

  // Input stalls only while an unconsumed result is pending.
  assign s_ready = !m_valid_q || m_ready;
  assign acc     = s_valid && s_ready;

  always_comb begin
    lp = '0;
    for (int k = 0; k < LANES; k++) begin
      lp[k] = ^s_data[k*L +: L];
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_acc_d   = lane_acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    mode_d       = mode_q;
    m_valid_d    = m_valid_q;
    m_parity_d   = m_parity_q;
    m_total_d    = m_total_q;
    m_count_d    = m_count_q;
    m_overflow_d = m_overflow_q;

    if (acc) begin
      if (state_q == IDLE) begin
        lane_acc_d = lp;
        cnt_d      = CNT_ONE;
        ovf_d      = 1'b0;
        mode_d     = cfg_odd;
      end else begin
        lane_acc_d = lane_acc_q ^ lp;
        if (&cnt_q) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      state_d = s_last ? IDLE : ACCUM;
    end

    // A new record takes priority over a drain in the same cycle, which keeps
    // m_valid high and gives one frame per cycle throughput.
    if (acc && s_last) begin
      m_valid_d    = 1'b1;
      m_parity_d   = lane_acc_d ^ {LANES{mode_d}};
      m_total_d    = (^lane_acc_d) ^ mode_d;
      m_count_d    = cnt_d;
      m_overflow_d = ovf_d;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lane_acc_q   <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      mode_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_parity_q   <= '0;
      m_total_q    <= 1'b0;
      m_count_q    <= '0;
      m_overflow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_acc_q   <= lane_acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      mode_q       <= mode_d;
      m_valid_q    <= m_valid_d;
      m_parity_q   <= m_parity_d;
      m_total_q    <= m_total_d;
      m_count_q    <= m_count_d;
      m_overflow_q <= m_overflow_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_parity   = m_parity_q;
  assign m_total    = m_total_q;
  assign m_count    = m_count_q;
  assign m_overflow = m_overflow_q;

endmodule
